// File: rtl/segment_capture.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : segment_capture                                            |
// | Description : Passive receiver for an eight-digit, active-low,           |
// |               time-multiplexed seven-segment bus. Decodes each settled   |
// |               digit back to a hex nibble and presents the rebuilt 32-bit |
// |               value once all eight positions have been seen.             |
// |               Optional feature macro: SEGCAP_DP_CHECK_EN (a lit decimal  |
// |               point on a selected digit rejects that digit).             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module segment_capture #(
    parameter int SETTLE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  anodes,
    input  logic [7:0]  cathodes,
    output logic [31:0] number_out,
    output logic        frame_valid,
    output logic        digit_valid,
    output logic [2:0]  digit_index,
    output logic [3:0]  digit_value,
    output logic        pattern_err,
    output logic        anode_err
);

    localparam logic [3:0] c_settle    = 4'(SETTLE);
    localparam logic [1:0] c_st_wait   = 2'd0;
    localparam logic [1:0] c_st_armed  = 2'd1;
    localparam logic [1:0] c_st_held   = 2'd2;

    logic [15:0] r_prev;
    logic [3:0]  r_age;
    logic [1:0]  r_state;
    logic [31:0] r_shadow;
    logic [7:0]  r_mask;

    logic [15:0] w_sample;
    logic        w_same;
    logic [3:0]  w_age_next;
    logic [1:0]  w_state_next;
    logic        w_arm;
    logic        w_seg_ok;
    logic [3:0]  w_nib;
    logic        w_blank;
    logic        w_onehot;
    logic [2:0]  w_idx;
    logic        w_dp_bad;
    logic        w_accept;
    logic        w_perr;
    logic        w_aerr;
    logic [7:0]  w_mask_new;
    logic [31:0] w_shadow_new;

    // Dwell tracking: age counts edges with an unchanged sample; ARMED marks the single evaluation edge of a dwell.
    always_comb begin
        w_sample     = {anodes, cathodes};
        w_same       = (w_sample == r_prev);
        w_age_next   = r_age;
        w_state_next = r_state;
        if (!w_same) begin
            w_age_next   = 4'd1;
            w_state_next = (c_settle == 4'd1) ? c_st_armed : c_st_wait;
        end else begin
            w_age_next = (r_age >= c_settle) ? c_settle : r_age + 4'd1;
            if (r_state == c_st_wait) begin
                w_state_next = (w_age_next == c_settle) ? c_st_armed : c_st_wait;
            end else begin
                w_state_next = c_st_held;
            end
        end
        w_arm = (w_state_next == c_st_armed);
    end

    // Cathode pattern decode (segments a..g, active low) back to a nibble.
    always_comb begin
        w_seg_ok = 1'b1;
        w_nib    = 4'h0;
        case (cathodes[7:1])
            7'b0000001: w_nib = 4'h0;
            7'b1001111: w_nib = 4'h1;
            7'b0010010: w_nib = 4'h2;
            7'b0000110: w_nib = 4'h3;
            7'b1001100: w_nib = 4'h4;
            7'b0100100: w_nib = 4'h5;
            7'b0100000: w_nib = 4'h6;
            7'b0001111: w_nib = 4'h7;
            7'b0000000: w_nib = 4'h8;
            7'b0000100: w_nib = 4'h9;
            7'b0001000: w_nib = 4'hA;
            7'b1100000: w_nib = 4'hB;
            7'b0110001: w_nib = 4'hC;
            7'b1000010: w_nib = 4'hD;
            7'b0110000: w_nib = 4'hE;
            7'b0111000: w_nib = 4'hF;
            default:    w_seg_ok = 1'b0;
        endcase
    end

    // Anode classification, digit index and the accept / error decisions for an armed sample.
    always_comb begin
        w_blank  = (anodes == 8'hFF);
        w_onehot = $onehot(~anodes);
        w_idx    = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!anodes[i]) w_idx = 3'(i);
        end
`ifdef SEGCAP_DP_CHECK_EN
        w_dp_bad = ~cathodes[0];
`else
        w_dp_bad = 1'b0;
`endif
        w_accept     = w_arm && !w_blank && w_onehot && w_seg_ok && !w_dp_bad;
        w_perr       = w_arm && !w_blank && w_onehot && !(w_seg_ok && !w_dp_bad);
        w_aerr       = w_arm && !w_blank && !w_onehot;
        w_mask_new   = r_mask | (8'd1 << w_idx);
        w_shadow_new = r_shadow;
        w_shadow_new[{w_idx, 2'b00} +: 4] = w_nib;
    end

    // State, shadow frame and registered outputs; pulses default low every cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev      <= 16'h0000;
            r_age       <= 4'd0;
            r_state     <= c_st_wait;
            r_shadow    <= 32'h0;
            r_mask      <= 8'h00;
            number_out  <= 32'h0;
            frame_valid <= 1'b0;
            digit_valid <= 1'b0;
            digit_index <= 3'd0;
            digit_value <= 4'h0;
            pattern_err <= 1'b0;
            anode_err   <= 1'b0;
        end else begin
            r_prev      <= w_sample;
            r_age       <= w_age_next;
            r_state     <= w_state_next;
            frame_valid <= 1'b0;
            digit_valid <= w_accept;
            pattern_err <= w_perr;
            anode_err   <= w_aerr;
            if (w_accept) begin
                digit_index <= w_idx;
                digit_value <= w_nib;
                r_shadow    <= w_shadow_new;
                if (w_mask_new == 8'hFF) begin
                    number_out  <= w_shadow_new;
                    frame_valid <= 1'b1;
                    r_mask      <= 8'h00;
                end else begin
                    r_mask <= w_mask_new;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_segment_capture.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_segment_capture                                         |
// | Description : Directed self-checking bench for segment_capture; one      |
// |               instance with SETTLE=1 and one with SETTLE=2 share inputs. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_segment_capture;

    logic        clk;
    logic        reset;
    logic [7:0]  anodes;
    logic [7:0]  cathodes;

    logic [31:0] num1, num2;
    logic        fv1, fv2, dv1, dv2, pe1, pe2, ae1, ae2;
    logic [2:0]  di1, di2;
    logic [3:0]  dval1, dval2;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_fv   = 0;

    segment_capture #(.SETTLE(1)) u_dut1 (
        .clk(clk), .reset(reset), .anodes(anodes), .cathodes(cathodes),
        .number_out(num1), .frame_valid(fv1), .digit_valid(dv1),
        .digit_index(di1), .digit_value(dval1), .pattern_err(pe1), .anode_err(ae1)
    );

    segment_capture #(.SETTLE(2)) u_dut2 (
        .clk(clk), .reset(reset), .anodes(anodes), .cathodes(cathodes),
        .number_out(num2), .frame_valid(fv2), .digit_valid(dv2),
        .digit_index(di2), .digit_value(dval2), .pattern_err(pe2), .anode_err(ae2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-encoded cathode bytes {a..g, dp}, DP off.
    function automatic logic [7:0] seg(input logic [3:0] n);
        case (n)
            4'h0: seg = 8'h03; 4'h1: seg = 8'h9F; 4'h2: seg = 8'h25; 4'h3: seg = 8'h0D;
            4'h4: seg = 8'h99; 4'h5: seg = 8'h49; 4'h6: seg = 8'h41; 4'h7: seg = 8'h1F;
            4'h8: seg = 8'h01; 4'h9: seg = 8'h09; 4'hA: seg = 8'h11; 4'hB: seg = 8'hC1;
            4'hC: seg = 8'h63; 4'hD: seg = 8'h85; 4'hE: seg = 8'h61; default: seg = 8'h71;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] val;
    logic [3:0]  nib;

    initial begin
        reset    = 1'b1;
        anodes   = 8'hFF;
        cathodes = 8'hFF;
        tick();
        tick();
        check("rst_number", num1, 32'h0);
        check("rst_pulses", {28'h0, fv1, dv1, pe1, ae1}, 32'h0);
        check("rst_idx_val", {25'h0, di1, dval1}, 32'h0);
        reset = 1'b0;

        // Full frame, one digit per clock.
        val = 32'h1234_ABCD;
        for (int i = 0; i < 8; i++) begin
            nib      = val[4*i +: 4];
            anodes   = ~(8'h01 << i);
            cathodes = seg(nib);
            tick();
            check($sformatf("frm_dv%0d", i), {31'h0, dv1}, 32'h1);
            check($sformatf("frm_idx%0d", i), {29'h0, di1}, i);
            check($sformatf("frm_val%0d", i), {28'h0, dval1}, {28'h0, nib});
            check($sformatf("frm_fv%0d", i), {31'h0, fv1}, (i == 7) ? 32'h1 : 32'h0);
            check($sformatf("s2_short_dv%0d", i), {31'h0, dv2}, 32'h0);
        end
        check("frm_number", num1, 32'h1234_ABCD);

        // Blank display: no pulses at all.
        anodes   = 8'hFF;
        cathodes = 8'hFF;
        tick();
        tick();
        check("blank_pulses", {28'h0, fv1, dv1, pe1, ae1}, 32'h0);

        // SETTLE=2: one-cycle glitch then a three-cycle dwell.
        anodes   = 8'hFE;
        cathodes = seg(4'h5);
        tick();
        check("s2_glitch_dv", {31'h0, dv2}, 32'h0);
        check("s1_glitch_val", {27'h0, dv1, dval1}, 32'h15);
        anodes   = 8'hFD;
        cathodes = seg(4'h3);
        tick();
        check("s2_t1_dv", {31'h0, dv2}, 32'h0);
        tick();
        check("s2_t2_dv", {31'h0, dv2}, 32'h1);
        check("s2_t2_idx", {29'h0, di2}, 32'h1);
        check("s2_t2_val", {28'h0, dval2}, 32'h3);
        tick();
        check("s2_t3_dv", {31'h0, dv2}, 32'h0);
        check("s1_held_dv", {31'h0, dv1}, 32'h0);

        // Unrecognised pattern on a valid anode.
        anodes   = 8'hFE;
        cathodes = 8'hFF;
        tick();
        check("perr_pulse", {29'h0, pe1, dv1, ae1}, 32'h4);
        tick();
        check("perr_once", {31'h0, pe1}, 32'h0);

        // Two anodes low, then blank.
        anodes   = 8'hFC;
        cathodes = seg(4'h1);
        tick();
        check("aerr_pulse", {29'h0, ae1, dv1, pe1}, 32'h4);
        anodes = 8'hFF;
        tick();
        check("aerr_blank", {29'h0, ae1, dv1, pe1}, 32'h0);

        // Partial frame of F's, reset, then a clean frame of 7.
        for (int i = 0; i < 4; i++) begin
            anodes   = ~(8'h01 << i);
            cathodes = seg(4'hF);
            tick();
            check($sformatf("part_fv%0d", i), {31'h0, fv1}, 32'h0);
        end
        anodes   = 8'hFF;
        cathodes = 8'hFF;
        reset    = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_mid_number", num1, 32'h0);
        n_fv = 0;
        val  = 32'h0000_0007;
        for (int i = 0; i < 8; i++) begin
            nib      = val[4*i +: 4];
            anodes   = ~(8'h01 << i);
            cathodes = seg(nib);
            tick();
            if (fv1) n_fv++;
            check($sformatf("rf_fv%0d", i), {31'h0, fv1}, (i == 7) ? 32'h1 : 32'h0);
        end
        check("rf_fv_count", n_fv, 32'h1);
        check("rf_number", num1, 32'h0000_0007);

        // Digit 8 with the decimal point lit.
        anodes   = 8'hFE;
        cathodes = 8'h00;
        tick();
`ifdef SEGCAP_DP_CHECK_EN
        check("dp_reject", {30'h0, pe1, dv1}, 32'h2);
`else
        check("dp_ignored", {30'h0, pe1, dv1}, 32'h1);
        check("dp_value", {25'h0, di1, dval1}, 32'h08);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
